// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator: one bit of A and B per accepted cycle, result strobe
// one cycle after the last bit; in_valid=0 stalls all state, abort drops the word in progress.
module serial_word_comparator #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic abort,
  output logic busy,
  output logic out_valid,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  logic [CW-1:0] cnt;
  rel_t          rel;
  rel_t          d;
  rel_t          rel_next;
  logic          last_bit;
  logic          sign_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign sign_bit = (MSB_FIRST != 0) ? (cnt == '0) : last_bit;

  // Two's complement: a 1 in the sign position makes the operand smaller, so the sense flips.
  always_comb begin
    d = REL_EQ;
    if (!a && b)
      d = (SIGNED != 0 && sign_bit) ? REL_GT : REL_LT;
    else if (a && !b)
      d = (SIGNED != 0 && sign_bit) ? REL_LT : REL_GT;
  end

  always_comb begin
    rel_next = rel;
    if (d != REL_EQ) begin
      if (MSB_FIRST != 0) begin
        if (rel == REL_EQ)
          rel_next = d;
      end else begin
        rel_next = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rel         <= REL_EQ;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      a_less_b    <= 1'b0;
      a_eq_b      <= 1'b1;
      a_greater_b <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (abort) begin
        cnt  <= '0;
        rel  <= REL_EQ;
        busy <= 1'b0;
      end else if (in_valid) begin
        if (last_bit) begin
          cnt         <= '0;
          rel         <= REL_EQ;
          busy        <= 1'b0;
          out_valid   <= 1'b1;
          a_less_b    <= (rel_next == REL_LT);
          a_eq_b      <= (rel_next == REL_EQ);
          a_greater_b <= (rel_next == REL_GT);
        end else begin
          cnt  <= cnt + CW'(1);
          rel  <= rel_next;
          busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Three comparators (MSB/unsigned, MSB/signed, LSB/signed) share framing; a scoreboard
// of arithmetic expectations is checked on every result strobe.
module tb_serial_word_comparator;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, abort;
  logic am, bm, al, bl;
  logic busy0, busy1, busy2;
  logic ov0, ov1, ov2;
  logic lt0, eq0, gt0, lt1, eq1, gt1, lt2, eq2, gt2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [8:0] exp_q[$];
  logic [8:0] hold;

  always #5 clk = ~clk;

  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(am), .b(bm), .abort(abort),
    .busy(busy0), .out_valid(ov0), .a_less_b(lt0), .a_eq_b(eq0), .a_greater_b(gt0));
  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(am), .b(bm), .abort(abort),
    .busy(busy1), .out_valid(ov1), .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1));
  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(0), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(al), .b(bl), .abort(abort),
    .busy(busy2), .out_valid(ov2), .a_less_b(lt2), .a_eq_b(eq2), .a_greater_b(gt2));

  wire [8:0] flags = {lt0, eq0, gt0, lt1, eq1, gt1, lt2, eq2, gt2};
  wire [2:0] busys = {busy0, busy1, busy2};
  wire [2:0] ovs   = {ov0, ov1, ov2};

  function automatic logic [2:0] rel3(logic [7:0] x, logic [7:0] y, bit sgn);
    int xi, yi;
    xi = sgn ? int'($signed(x)) : int'(x);
    yi = sgn ? int'($signed(y)) : int'(y);
    return {xi < yi, xi == yi, xi > yi};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(logic [7:0] x, logic [7:0] y, int i);
    in_valid = 1'b1;
    am = x[7-i];
    bm = y[7-i];
    al = x[i];
    bl = y[i];
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(logic [7:0] x, logic [7:0] y, bit stalls);
    exp_q.push_back({rel3(x, y, 1'b0), rel3(x, y, 1'b1), rel3(x, y, 1'b1)});
    for (int i = 0; i < 8; i++) begin
      while (stalls && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        step();
      end
      drive_bit(x, y, i);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 9'b010_010_010;
        continue;
      end
      if (ovs != 3'b000) begin
        checks++;
        if (ovs !== 3'b111) begin
          errors++;
          $display("FAIL strobe_align: out_valid=%b required 111", ovs);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: out_valid=%b with no word expected", ovs);
        end else begin
          e = exp_q.pop_front();
          pulses++;
          if (flags !== e) begin
            errors++;
            $display("FAIL result_flags: got %b required %b", flags, e);
          end
          hold = e;
        end
      end else begin
        checks++;
        if (flags !== hold) begin
          errors++;
          $display("FAIL flags_held: got %b required %b", flags, hold);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({busys, ovs, flags} !== {3'b000, 3'b000, 9'b010_010_010}) begin
      errors++;
      $display("FAIL reset_values: busy=%b ov=%b flags=%b required 000 000 010010010",
               busys, ovs, flags);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int p0;
    p0 = pulses;
    exp_q.push_back({rel3(8'h5A, 8'h5B, 1'b0), rel3(8'h5A, 8'h5B, 1'b1), rel3(8'h5A, 8'h5B, 1'b1)});
    for (int i = 0; i < 8; i++) begin
      drive_bit(8'h5A, 8'h5B, i);
      if (i == 0) begin
        checks++;
        if (busys !== 3'b111) begin
          errors++;
          $display("FAIL busy_rise: busy=%b required 111", busys);
        end
      end
    end
    checks++;
    if (ovs !== 3'b111 || busys !== 3'b000) begin
      errors++;
      $display("FAIL latency: ov=%b busy=%b required 111 000 right after last bit", ovs, busys);
    end
    checks++;
    if ({lt0, eq0, gt0} !== 3'b100) begin
      errors++;
      $display("FAIL basic_lt: flags=%b required 100", {lt0, eq0, gt0});
    end
    step();
    checks++;
    if (ovs !== 3'b000) begin
      errors++;
      $display("FAIL single_cycle_strobe: ov=%b required 000", ovs);
    end
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL basic_count: pulses=%0d required 1", pulses - p0);
    end
  endtask

  task automatic test_signedness();
    send_word(8'h80, 8'h01, 1'b0);
    send_word(8'hFF, 8'hFF, 1'b0);
    send_word(8'h81, 8'h80, 1'b0);
    send_word(8'h7F, 8'hFF, 1'b0);
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL signedness_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    for (int w = 0; w < 3; w++)
      send_word(8'($urandom), 8'($urandom), 1'b1);
    step();
    step();
    checks++;
    if (pulses - p0 != 3) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d required 3", pulses - p0);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 4; i++)
      drive_bit(8'h5A, 8'h00, i);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busys !== 3'b000) begin
      errors++;
      $display("FAIL abort_busy: busy=%b required 000", busys);
    end
    // Abort wins over a simultaneous bit: that bit must not start a word.
    abort = 1'b1;
    drive_bit(8'hFF, 8'h00, 0);
    abort = 1'b0;
    checks++;
    if (busys !== 3'b000) begin
      errors++;
      $display("FAIL abort_with_valid: busy=%b required 000", busys);
    end
    send_word(8'h10, 8'h10, 1'b0);
    step();
    checks++;
    if (pulses - p0 != 1 || flags !== 9'b010_010_010) begin
      errors++;
      $display("FAIL abort_then_word: pulses=%0d flags=%b required 1 010010010",
               pulses - p0, flags);
    end
  endtask

  task automatic test_reset_midword();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 5; i++)
      drive_bit(8'h0F, 8'hF0, i);
    rst = 1'b0;
    #2;
    checks++;
    if ({busys, ovs, flags} !== {3'b000, 3'b000, 9'b010_010_010}) begin
      errors++;
      $display("FAIL reset_midword: busy=%b ov=%b flags=%b required 000 000 010010010",
               busys, ovs, flags);
    end
    step();
    rst = 1'b1;
    step();
    send_word(8'h01, 8'h02, 1'b0);
    step();
    step();
    checks++;
    if (pulses - p0 != 1 || {lt0, eq0, gt0} !== 3'b100) begin
      errors++;
      $display("FAIL reset_then_word: pulses=%0d flags=%b required 1 100",
               pulses - p0, {lt0, eq0, gt0});
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    abort = 1'b0;
    am = 1'b0;
    bm = 1'b0;
    al = 1'b0;
    bl = 1'b0;
    hold = 9'b010_010_010;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_signedness();
    test_back_to_back();
    test_abort();
    test_reset_midword();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
